// File: rtl/dcache_if.sv
// Load/invalidate/memory-port bundle between the load/store buffer,
// the byte-wide memory arbiter and the data cache.
// slave  : cache side.
// master : requester / arbiter side.
`ifndef INST_OPT_TP
`define INST_OPT_TP logic [2:0]
`endif

interface dcache_if;
  logic              rd_ena;
  logic [31:0]       rd_addr;
  `INST_OPT_TP       rd_opt;
  logic              rd_hit;
  logic [31:0]       rd_hit_dat;
  logic              inv_ena;
  logic [31:0]       inv_addr;
  logic              mem_req;
  logic              mem_gnt;
  logic [31:0]       mem_a;
  logic [7:0]        mem_din;

  modport slave (
    input  rd_ena, rd_addr, rd_opt, inv_ena, inv_addr, mem_gnt, mem_din,
    output rd_hit, rd_hit_dat, mem_req, mem_a
  );

  modport master (
    output rd_ena, rd_addr, rd_opt, inv_ena, inv_addr, mem_gnt, mem_din,
    input  rd_hit, rd_hit_dat, mem_req, mem_a
  );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, one-word-per-line load cache refilled over a byte-wide
// memory port. Build option DCACHE_STORAGE_EN: when defined, tag/data/valid
// arrays and the hit path exist; when undefined every load refills from
// memory with identical timing and invalidates are ignored.
`ifndef INST_OPT_TP
`define INST_OPT_TP logic [2:0]
`endif

module dcache #(
  parameter int DC_IDX_BIT = 6
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_rdy,
  input  logic     i_rb,
  dcache_if.slave  bus
);
  localparam logic [2:0] OPT_LB  = 3'd0;
  localparam logic [2:0] OPT_LH  = 3'd1;
  localparam logic [2:0] OPT_LBU = 3'd4;
  localparam logic [2:0] OPT_LHU = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESP, S_COOL} state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_addr;
  `INST_OPT_TP r_opt;
  logic [31:0] r_line;
  logic [31:0] r_mem_a;
  logic [2:0]  r_iss_cnt;   // addresses granted so far (0..4)
  logic [2:0]  r_cap_cnt;   // bytes captured so far (0..4)
  logic        r_pend;      // a byte is due on mem_din this cycle
  logic        r_hit;
  logic [31:0] r_hit_dat;
  logic        w_accept;
  logic        w_lookup_hit;
  logic [31:0] w_lookup_dat;

  // Select and extend the addressed byte/half/word from a full line.
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0] off,
                                          input logic [2:0] opt);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (opt)
      OPT_LB:  extract = {{24{b[7]}}, b};
      OPT_LBU: extract = {24'd0, b};
      OPT_LH:  extract = {{16{h[15]}}, h};
      OPT_LHU: extract = {16'd0, h};
      default: extract = word;
    endcase
  endfunction

  assign w_accept = (r_state == S_IDLE) && bus.rd_ena && !i_rb;

`ifdef DCACHE_STORAGE_EN
  localparam int TAG_W = 30 - DC_IDX_BIT;
  localparam int LINES = 2 ** DC_IDX_BIT;

  logic [TAG_W-1:0]      r_tag  [LINES];
  logic [31:0]           r_data [LINES];
  logic [LINES-1:0]      r_valid;
  logic                  r_inv_hit;  // in-flight line was invalidated
  logic [DC_IDX_BIT-1:0] w_rd_idx, w_inv_idx, w_ins_idx;
  logic                  w_inv_clr, w_inv_req, w_install;
  logic [1:0]            w_unused_inv;

  assign w_rd_idx  = bus.rd_addr[DC_IDX_BIT+1:2];
  assign w_inv_idx = bus.inv_addr[DC_IDX_BIT+1:2];
  assign w_ins_idx = r_addr[DC_IDX_BIT+1:2];
  // Lookup reads current contents, so a same-cycle invalidate is not seen.
  assign w_lookup_hit = r_valid[w_rd_idx] &&
                        (r_tag[w_rd_idx] == bus.rd_addr[31:DC_IDX_BIT+2]);
  assign w_lookup_dat = r_data[w_rd_idx];
  assign w_inv_clr = bus.inv_ena &&
                     (r_tag[w_inv_idx] == bus.inv_addr[31:DC_IDX_BIT+2]);
  assign w_inv_req = bus.inv_ena && (bus.inv_addr[31:2] == r_addr[31:2]);
  // I/O space (addr[17:16]==3) is never installed.
  assign w_install = (r_state == S_RESP) && !i_rb && !r_inv_hit &&
                     !w_inv_req && (r_addr[17:16] != 2'b11);
  assign w_unused_inv = bus.inv_addr[1:0];

  // Valid bits: invalidate first, install last so a new line wins its slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_rdy) begin
      if (w_inv_clr) r_valid[w_inv_idx] <= 1'b0;
      if (w_install) r_valid[w_ins_idx] <= 1'b1;
    end
  end

  // Tag/data arrays, written only on line install.
  always_ff @(posedge clk) begin
    if (i_rdy && w_install) begin
      r_tag[w_ins_idx]  <= r_addr[31:DC_IDX_BIT+2];
      r_data[w_ins_idx] <= r_line;
    end
  end

  // Remember an invalidate aimed at the word currently being fetched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inv_hit <= 1'b0;
    end else if (i_rdy) begin
      if (w_accept)
        r_inv_hit <= bus.inv_ena && (bus.inv_addr[31:2] == bus.rd_addr[31:2]);
      else if (w_inv_req)
        r_inv_hit <= 1'b1;
    end
  end
`else
  logic                  w_unused_inv;
  logic [DC_IDX_BIT-1:0] w_unused_idx;

  assign w_lookup_hit = 1'b0;
  assign w_lookup_dat = '0;
  assign w_unused_idx = bus.inv_addr[DC_IDX_BIT+1:2];
  assign w_unused_inv = ^{bus.inv_ena, bus.inv_addr, r_addr[31:2]};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst)        r_state <= S_IDLE;
    else if (i_rdy) r_state <= w_state_next;
  end

  // Next-state logic; rollback always returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.rd_ena) w_state_next = w_lookup_hit ? S_COOL : S_REFILL;
      S_REFILL: if (r_pend && (r_cap_cnt == 3'd3)) w_state_next = S_RESP;
      S_RESP:   w_state_next = S_COOL;
      S_COOL:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
    if (i_rb) w_state_next = S_IDLE;
  end

  // Request latch, byte fetch sequencing, line assembly and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_opt     <= '0;
      r_line    <= '0;
      r_mem_a   <= '0;
      r_iss_cnt <= '0;
      r_cap_cnt <= '0;
      r_pend    <= 1'b0;
      r_hit     <= 1'b0;
      r_hit_dat <= '0;
    end else if (i_rdy) begin
      r_hit <= 1'b0;
      if (i_rb) begin
        r_pend    <= 1'b0;
        r_iss_cnt <= '0;
        r_cap_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_addr    <= bus.rd_addr;
              r_opt     <= bus.rd_opt;
              r_mem_a   <= {bus.rd_addr[31:2], 2'b00};
              r_iss_cnt <= '0;
              r_cap_cnt <= '0;
              r_pend    <= 1'b0;
              if (w_lookup_hit) begin
                r_hit     <= 1'b1;
                r_hit_dat <= extract(w_lookup_dat, bus.rd_addr[1:0], bus.rd_opt);
              end
            end
          end
          S_REFILL: begin
            r_pend <= bus.mem_gnt && (r_iss_cnt != 3'd4);
            if (bus.mem_gnt && (r_iss_cnt != 3'd4)) begin
              r_iss_cnt <= r_iss_cnt + 3'd1;
              if (r_iss_cnt != 3'd3) r_mem_a <= r_mem_a + 32'd1;
            end
            if (r_pend) begin
              r_line[{r_cap_cnt[1:0], 3'b000} +: 8] <= bus.mem_din;
              r_cap_cnt <= r_cap_cnt + 3'd1;
            end
          end
          S_RESP: begin
            r_hit     <= 1'b1;
            r_hit_dat <= extract(r_line, r_addr[1:0], r_opt);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rd_hit     = r_hit;
  assign bus.rd_hit_dat = r_hit_dat;
  assign bus.mem_req    = (r_state == S_REFILL);
  assign bus.mem_a      = r_mem_a;
endmodule
